// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
// Define MDU_EARLY_OUT_EN to finish a multiply as soon as the remaining multiplier is zero.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] Result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned W2    = 2 * WIDTH;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t             state, state_n;
  logic               busy_n, done_n, div_zero_n;
  logic [WIDTH-1:0]   hi_n, lo_n, result_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [W2-1:0]      mcand, mcand_n, prod, prod_n;
  logic [WIDTH-1:0]   mplier, mplier_n;
  logic [WIDTH-1:0]   rem, rem_n, quot, quot_n, dvsr, dvsr_n, a_raw, a_raw_n;
  logic               neg_q, neg_q_n, neg_r, neg_r_n, is_div, is_div_n;
  logic               finish;

  logic               signed_op;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     rem_sh;

  assign signed_op = (operation == OP_MULT) || (operation == OP_DIV);
  assign abs_a     = (signed_op && a[WIDTH-1]) ? (-a) : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? (-b) : b;
  // Partial remainder with the next dividend bit shifted in from the quotient register
  assign rem_sh    = {rem, quot[WIDTH-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      divZero <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      Result  <= '0;
      cnt     <= '0;
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
      rem     <= '0;
      quot    <= '0;
      dvsr    <= '0;
      a_raw   <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_div  <= 1'b0;
    end else begin
      state   <= state_n;
      busy    <= busy_n;
      done    <= done_n;
      divZero <= div_zero_n;
      hi      <= hi_n;
      lo      <= lo_n;
      Result  <= result_n;
      cnt     <= cnt_n;
      mcand   <= mcand_n;
      prod    <= prod_n;
      mplier  <= mplier_n;
      rem     <= rem_n;
      quot    <= quot_n;
      dvsr    <= dvsr_n;
      a_raw   <= a_raw_n;
      neg_q   <= neg_q_n;
      neg_r   <= neg_r_n;
      is_div  <= is_div_n;
    end
  end

  always_comb begin
    state_n    = state;
    done_n     = 1'b0;
    div_zero_n = divZero;
    hi_n       = hi;
    lo_n       = lo;
    result_n   = Result;
    cnt_n      = cnt;
    mcand_n    = mcand;
    prod_n     = prod;
    mplier_n   = mplier;
    rem_n      = rem;
    quot_n     = quot;
    dvsr_n     = dvsr;
    a_raw_n    = a_raw;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    is_div_n   = is_div;
    finish     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          case (operation)
            OP_MTHI: begin hi_n = a;      done_n = 1'b1; div_zero_n = 1'b0; end
            OP_MTLO: begin lo_n = a;      done_n = 1'b1; div_zero_n = 1'b0; end
            OP_MFHI: begin result_n = hi; done_n = 1'b1; div_zero_n = 1'b0; end
            OP_MFLO: begin result_n = lo; done_n = 1'b1; div_zero_n = 1'b0; end
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              neg_q_n    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_r_n    = signed_op & a[WIDTH-1];
              cnt_n      = '0;
              div_zero_n = 1'b0;
              if ((operation == OP_DIV) || (operation == OP_DIVU)) begin
                is_div_n = 1'b1;
                quot_n   = abs_a;
                dvsr_n   = abs_b;
                rem_n    = '0;
                a_raw_n  = a;
                state_n  = DIV;
              end else begin
                is_div_n = 1'b0;
                mcand_n  = {{WIDTH{1'b0}}, abs_a};
                mplier_n = abs_b;
                prod_n   = '0;
                state_n  = MUL;
              end
            end
            default: ;
          endcase
        end
      end
      MUL: begin
`ifdef MDU_EARLY_OUT_EN
        finish = (mplier == '0);
`endif
        if (!finish) begin
          if (mplier[0]) prod_n = prod + mcand;
          mcand_n  = mcand << 1;
          mplier_n = mplier >> 1;
          cnt_n    = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) state_n = FIN;
        end
      end
      DIV: begin
        if (rem_sh >= {1'b0, dvsr}) begin
          rem_n  = WIDTH'(rem_sh - {1'b0, dvsr});
          quot_n = {quot[WIDTH-2:0], 1'b1};
        end else begin
          rem_n  = rem_sh[WIDTH-1:0];
          quot_n = {quot[WIDTH-2:0], 1'b0};
        end
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_n = FIN;
      end
      FIN:     finish = 1'b1;
      default: state_n = IDLE;
    endcase

    // Sign correction and architectural write-back
    if (finish) begin
      state_n = IDLE;
      done_n  = 1'b1;
      if (is_div) begin
        if (dvsr == '0) begin
          lo_n       = '1;
          hi_n       = a_raw;
          div_zero_n = 1'b1;
        end else begin
          lo_n = neg_q ? (-quot) : quot;
          hi_n = neg_r ? (-rem) : rem;
        end
      end else begin
        {hi_n, lo_n} = neg_q ? (-prod) : prod;
      end
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32); honours MDU_EARLY_OUT_EN.
module tb_mult_div_unit;

  localparam logic [5:0] OP_MULT  = 6'b011000;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIV   = 6'b011010;
  localparam logic [5:0] OP_DIVU  = 6'b011011;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MTHI  = 6'b010001;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MTLO  = 6'b010011;

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_MULTU_FF_2 = 3;
  localparam int LAT_MULTU_5_3  = 3;
`else
  localparam int LAT_MULTU_FF_2 = 33;
  localparam int LAT_MULTU_5_3  = 33;
`endif

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  operation;
  logic [31:0] a, b;
  logic        busy, done, divZero;
  logic [31:0] hi, lo, Result;

  int checks = 0;
  int fails  = 0;
  int lat, bcyc, n, seen;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .operation(operation),
    .a(a), .b(b), .busy(busy), .done(done), .divZero(divZero),
    .hi(hi), .lo(lo), .Result(Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a request for exactly one rising edge (E0); returns #1 after E0
  task automatic drive(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; operation = op; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue and wait for done; lat = edges after E0 at which done was seen
  task automatic run(input string tag, input logic [5:0] op, input logic [31:0] av,
                     input logic [31:0] bv, output int l, output int bc);
    drive(op, av, bv);
    l  = 0;
    bc = busy ? 1 : 0;
    while (!done && l < 200) begin
      @(posedge clk); #1;
      l++;
      if (busy) bc++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; operation = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_divzero", divZero, 0);
    check("rst_hilo", {hi, lo}, 64'h0);
    check("rst_result", Result, 0);
    @(negedge clk) reset_n = 1'b1;

    run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, lat, bcyc);
    check("multu_hi", hi, 32'h0000_0001);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    check("multu_lat", lat, LAT_MULTU_FF_2);
    check("multu_busy_cycles", bcyc, LAT_MULTU_FF_2);
    check("multu_busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("multu_done_pulse", done, 0);

    run("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
    check("multu_max_prod", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

    run("mult", OP_MULT, 32'hFFFF_FFFD, 32'h7, lat, bcyc);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);

    run("div", OP_DIV, 32'hFFFF_FFF9, 32'h2, lat, bcyc);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lat", lat, 33);

    run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0);
    check("div_ovf_dz", divZero, 0);

    run("divu_z", OP_DIVU, 32'd100, 32'h0, lat, bcyc);
    check("divu_z_lo", lo, 32'hFFFF_FFFF);
    check("divu_z_hi", hi, 32'd100);
    check("divu_z_dz", divZero, 1);
    check("divu_z_lat", lat, 33);

    run("mthi", OP_MTHI, 32'h1234, 32'h0, lat, bcyc);
    check("mthi_lat", lat, 0);
    check("mthi_busy", busy, 0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_dz_clear", divZero, 0);
    run("mfhi", OP_MFHI, 32'h0, 32'h0, lat, bcyc);
    check("mfhi_lat", lat, 0);
    check("mfhi_result", Result, 32'h1234);

    run("mtlo", OP_MTLO, 32'h55, 32'h0, lat, bcyc);
    run("mflo", OP_MFLO, 32'h0, 32'h0, lat, bcyc);
    check("mflo_result", Result, 32'h55);
    run("mthi2", OP_MTHI, 32'h99, 32'h0, lat, bcyc);
    check("result_hold", Result, 32'h55);

    drive(6'b000000, 32'hABCD, 32'h0);
    check("unknown_done", done, 0);
    check("unknown_busy", busy, 0);
    check("unknown_hi", hi, 32'h99);

    // Start while busy must be dropped: DIVU 50/7 -> q=7 r=1
    drive(OP_DIVU, 32'd50, 32'd7);
    n = 0;
    repeat (3) begin @(posedge clk); n++; end
    @(negedge clk);
    start = 1'b1; operation = OP_MTHI; a = 32'hDEAD;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    check("busy_ignore_nodone", done, 0);
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    check("busy_ignore_lat", n, 33);
    check("busy_ignore_hi", hi, 32'd1);
    check("busy_ignore_lo", lo, 32'd7);
    @(posedge clk); #1;
    check("busy_ignore_single_done", done, 0);

    // Asynchronous reset mid-divide
    drive(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_hilo", {hi, lo}, 64'h0);
    @(negedge clk) reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("arst_no_done", seen, 0);
    check("arst_hilo_after", {hi, lo}, 64'h0);

    run("multu_5_3", OP_MULTU, 32'd5, 32'd3, lat, bcyc);
    check("multu_5_3_lo", lo, 32'd15);
    check("multu_5_3_hi", hi, 32'd0);
    check("multu_5_3_lat", lat, LAT_MULTU_5_3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
